// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- memory-stage load/store unit.
//
// Takes the ALU result from EX either as an effective address (loads/stores)
// or as a finished result (everything else). Memory ops are turned into one
// byte-masked data-cache request; loads then wait for the response word,
// pick the addressed lane, extend it and hand it to writeback.
//
// Ports
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   in_valid/ready    EX handshake; ready only while the unit is idle
//   in_opcode/funct3  instruction class and access width/sign
//   in_alu_out        effective address or pass-through result
//   in_store_data     rs2 value for stores
//   in_rd             destination register
//   dc_req_valid/ready, dc_we, dc_addr, dc_wdata   cache request channel
//   dc_resp_valid/data                              cache read response
//   wb_valid/rd/data  one-cycle writeback pulse
//   misalign          one-cycle pulse when an access is dropped
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  output logic            dc_req_valid,
  input  logic            dc_req_ready,
  output logic [3:0]      dc_we,
  output logic [XLEN-3:0] dc_addr,
  output logic [XLEN-1:0] dc_wdata,
  input  logic            dc_resp_valid,
  input  logic [XLEN-1:0] dc_resp_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t     state;
  logic [2:0] ld_f3;
  logic [1:0] ld_lane;
  logic [4:0] ld_rd;

  logic       is_load;
  logic       is_store;
  logic [1:0] lane;
  logic       access_ok;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] ln);
    case (f3[1:0])
      2'b00:   store_mask = 4'b0001 << ln;
      2'b01:   store_mask = 4'b0011 << ln;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero extend it.
  // LW is only reachable with lane 0, so the shifted word is the word.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] ln,
                                                  input logic [XLEN-1:0] word);
    logic [XLEN-1:0] sh;
    sh = word >> {ln, 3'b000};
    case (f3[1:0])
      2'b00:   load_extend = f3[2] ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                   : {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'b01:   load_extend = f3[2] ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                   : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  assign is_load  = (in_opcode == OP_LOAD);
  assign is_store = (in_opcode == OP_STORE);
  assign lane     = in_alu_out[1:0];
  assign in_ready = (state == IDLE);

  // Width legality and natural alignment; unsigned variants exist only for loads.
  always_comb begin
    access_ok = 1'b0;
    case (in_funct3)
      3'b000:  access_ok = 1'b1;
      3'b001:  access_ok = ~lane[0];
      3'b010:  access_ok = (lane == 2'b00);
      3'b100:  access_ok = is_load;
      3'b101:  access_ok = is_load & ~lane[0];
      default: access_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dc_req_valid <= 1'b0;
      dc_we        <= 4'b0000;
      dc_addr      <= '0;
      dc_wdata     <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      misalign     <= 1'b0;
      ld_f3        <= 3'd0;
      ld_lane      <= 2'd0;
      ld_rd        <= 5'd0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_load || is_store) begin
              if (!access_ok) begin
                misalign <= 1'b1;
              end else begin
                state        <= REQ;
                dc_req_valid <= 1'b1;
                dc_addr      <= in_alu_out[XLEN-1:2];
                dc_we        <= is_store ? store_mask(in_funct3, lane) : 4'b0000;
                if (is_store) dc_wdata <= in_store_data << {lane, 3'b000};
                ld_f3        <= in_funct3;
                ld_lane      <= lane;
                ld_rd        <= in_rd;
              end
            end else begin
              wb_valid <= 1'b1;
              wb_data  <= in_alu_out;
              wb_rd    <= in_rd;
            end
          end
        end
        // Request fields stay frozen until the cache takes them; a zero
        // mask marks a load, which then waits for its response word.
        REQ: begin
          if (dc_req_ready) begin
            dc_req_valid <= 1'b0;
            dc_we        <= 4'b0000;
            state        <= (dc_we == 4'b0000) ? WAIT : IDLE;
          end
        end
        WAIT: begin
          if (dc_resp_valid) begin
            wb_valid <= 1'b1;
            wb_data  <= load_extend(ld_f3, ld_lane, dc_resp_data);
            wb_rd    <= ld_rd;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int N = 1024;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_out;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [3:0]  dc_we;
  logic [29:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_alu_out(in_alu_out), .in_store_data(in_store_data),
    .in_rd(in_rd),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, indexed by the number of rising edges seen.
  bit          e_wb   [N];
  logic [4:0]  e_rd   [N];
  logic [31:0] e_wd   [N];
  bit          e_mis  [N];
  bit          e_req  [N];
  bit          e_busy [N];
  bit          e_chkw [N];
  logic [3:0]  e_we   [N];
  logic [29:0] e_addr [N];
  logic [31:0] e_wdata[N];

  int nchecks = 0;
  int nerrs   = 0;
  bit chk_en  = 1'b0;

  // Observations captured for the hand-computed literal checks.
  int          cnt_wb = 0, cnt_mis = 0, cnt_req = 0;
  logic [31:0] cap_wb_data = '0, cap_wdata = '0;
  logic [4:0]  cap_wb_rd = '0;
  logic [3:0]  cap_we = '0;
  logic [29:0] cap_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n && cyc < N) begin
      check("in_ready", 32'(in_ready), 32'(!e_busy[cyc]));
      check("dc_req_valid", 32'(dc_req_valid), 32'(e_req[cyc]));
      if (e_req[cyc]) begin
        check("dc_addr", 32'(dc_addr), 32'(e_addr[cyc]));
        check("dc_we", 32'(dc_we), 32'(e_we[cyc]));
        if (e_chkw[cyc]) check("dc_wdata", dc_wdata, e_wdata[cyc]);
      end
      check("wb_valid", 32'(wb_valid), 32'(e_wb[cyc]));
      if (e_wb[cyc]) begin
        check("wb_rd", 32'(wb_rd), 32'(e_rd[cyc]));
        check("wb_data", wb_data, e_wd[cyc]);
      end
      check("misalign", 32'(misalign), 32'(e_mis[cyc]));
    end
    if (rst_n) begin
      if (wb_valid) begin cnt_wb++; cap_wb_data = wb_data; cap_wb_rd = wb_rd; end
      if (misalign) cnt_mis++;
      if (dc_req_valid) begin cnt_req++; cap_we = dc_we; cap_addr = dc_addr; cap_wdata = dc_wdata; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes from funct3; 0 means no such width.
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    if (f3[1:0] == 2'b10) return 4;
    return 0;
  endfunction

  // Issue one instruction: record what the spec says must happen and when,
  // then play the cache side (s stall cycles on ready, response g cycles
  // after the WAIT state is entered).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input int s, input int g,
                       input logic [31:0] resp);
    int     acc, bytes, ln, e;
    bit     ld, st, ok;
    longint val;
    acc   = cyc + 1;
    ld    = (op == LOAD);
    st    = (op == STORE);
    bytes = size_of(f3);
    ln    = int'(a % 4);
    ok    = 1'b0;
    if (!ld && !st) begin
      e_wb[acc] = 1'b1; e_rd[acc] = rd; e_wd[acc] = a;
    end else begin
      ok = (bytes != 0) && (a % bytes == 0) && (st ? (f3[2] == 1'b0) : (f3 != 3'b110));
      if (!ok) begin
        e_mis[acc] = 1'b1;
      end else begin
        for (e = acc; e <= acc + s; e++) begin
          e_req[e]   = 1'b1;
          e_busy[e]  = 1'b1;
          e_addr[e]  = 30'(a / 4);
          e_we[e]    = st ? 4'(((1 << bytes) - 1) << ln) : 4'b0000;
          e_chkw[e]  = st;
          e_wdata[e] = 32'(longint'(sd) * (longint'(1) << (8 * ln)));
        end
        if (ld) begin
          for (e = acc + s + 1; e <= acc + s + 1 + g; e++) e_busy[e] = 1'b1;
          val = (longint'(resp) >> (8 * ln)) % (longint'(1) << (8 * bytes));
          if (!f3[2] && bytes < 4 && val >= (longint'(1) << (8 * bytes - 1)))
            val = val - (longint'(1) << (8 * bytes));
          e = acc + s + 2 + g;
          e_wb[e] = 1'b1; e_rd[e] = rd; e_wd[e] = 32'(val);
        end
      end
    end
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_alu_out = a;
    in_store_data = sd; in_rd = rd;
    step();
    in_valid = 1'b0;
    if ((ld || st) && ok) begin
      repeat (s) step();
      dc_req_ready = 1'b1;
      step();
      dc_req_ready = 1'b0;
      if (ld) begin
        repeat (g) step();
        dc_resp_valid = 1'b1; dc_resp_data = resp;
        step();
        dc_resp_valid = 1'b0;
      end
    end
    step();
  endtask

  int wb0, mis0, req0, acc6;

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_alu_out = '0;
    in_store_data = '0; in_rd = '0; dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0; dc_resp_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst dc_req_valid", 32'(dc_req_valid), 32'd0);
    check("rst dc_we", 32'(dc_we), 32'd0);
    check("rst dc_addr", 32'(dc_addr), 32'd0);
    check("rst dc_wdata", dc_wdata, 32'd0);
    check("rst wb_valid", 32'(wb_valid), 32'd0);
    check("rst wb_rd", 32'(wb_rd), 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst misalign", 32'(misalign), 32'd0);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;

    // 1: pass-through ALU result
    wb0 = cnt_wb;
    issue(ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0);
    check("t1 wb count", 32'(cnt_wb - wb0), 32'd1);
    check("t1 wb_data", cap_wb_data, 32'h0000_1234);
    check("t1 wb_rd", 32'(cap_wb_rd), 32'd5);

    // 2: LB / LBU from lane 3
    issue(LOAD, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 0, 0, 32'h80FF_0000);
    check("t2 dc_addr", 32'(cap_addr), 32'h40);
    check("t2 dc_we", 32'(cap_we), 32'h0);
    check("t2 LB data", cap_wb_data, 32'hFFFF_FF80);
    issue(LOAD, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 0, 1, 32'h80FF_0000);
    check("t2 LBU data", cap_wb_data, 32'h0000_0080);

    // 3: SH to upper half with three stalled cycles
    wb0 = cnt_wb; req0 = cnt_req;
    issue(STORE, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd9, 3, 0, 32'h0);
    check("t3 dc_we", 32'(cap_we), 32'hC);
    check("t3 dc_wdata", cap_wdata, 32'hBEEF_0000);
    check("t3 req cycles", 32'(cnt_req - req0), 32'd4);
    check("t3 no wb", 32'(cnt_wb - wb0), 32'd0);

    // 4: misaligned LW is dropped
    mis0 = cnt_mis; req0 = cnt_req;
    issue(LOAD, 3'b010, 32'h0000_0201, 32'h0, 5'd3, 0, 0, 32'h0);
    check("t4 misalign count", 32'(cnt_mis - mis0), 32'd1);
    check("t4 no request", 32'(cnt_req - req0), 32'd0);

    // 5: LH upper half, response 4 cycles after accept
    issue(LOAD, 3'b001, 32'h0000_0006, 32'h0, 5'd12, 0, 2, 32'h8001_7FFF);
    check("t5 LH data", cap_wb_data, 32'hFFFF_8001);

    // Further widths, lanes, faults and rd=0
    issue(STORE, 3'b000, 32'h0000_0301, 32'h1234_5678, 5'd0, 0, 0, 32'h0);
    check("SB dc_wdata", cap_wdata, 32'h3456_7800);
    issue(STORE, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 5'd0, 1, 0, 32'h0);
    check("SW dc_we", 32'(cap_we), 32'hF);
    issue(LOAD, 3'b101, 32'h0000_0002, 32'h0, 5'd4, 0, 0, 32'h8001_7FFF);
    check("LHU data", cap_wb_data, 32'h0000_8001);
    issue(LOAD, 3'b010, 32'h0000_0010, 32'h0, 5'd0, 2, 1, 32'hCAFE_F00D);
    check("LW rd0 data", cap_wb_data, 32'hCAFE_F00D);
    check("LW rd0 rd", 32'(cap_wb_rd), 32'd0);
    issue(LOAD, 3'b011, 32'h0000_0000, 32'h0, 5'd1, 0, 0, 32'h0);
    issue(STORE, 3'b100, 32'h0000_0000, 32'h0, 5'd1, 0, 0, 32'h0);
    issue(STORE, 3'b001, 32'h0000_0203, 32'h0, 5'd1, 0, 0, 32'h0);
    issue(ALU, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd31, 0, 0, 32'h0);

    // 6: reset while waiting for a load response, stale response afterwards
    wb0 = cnt_wb;
    acc6 = cyc + 1;
    e_req[acc6] = 1'b1; e_busy[acc6] = 1'b1; e_addr[acc6] = 30'h20; e_we[acc6] = 4'b0000;
    in_valid = 1'b1; in_opcode = LOAD; in_funct3 = 3'b010; in_alu_out = 32'h0000_0080; in_rd = 5'd6;
    step();
    in_valid = 1'b0; dc_req_ready = 1'b1;
    step();
    dc_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    check("t6 rst in_ready", 32'(in_ready), 32'd1);
    check("t6 rst req", 32'(dc_req_valid), 32'd0);
    rst_n = 1'b1;
    step();
    dc_resp_valid = 1'b1; dc_resp_data = 32'h1111_1111;
    step();
    dc_resp_valid = 1'b0;
    repeat (2) step();
    check("t6 no wb", 32'(cnt_wb - wb0), 32'd0);
    check("t6 idle", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
